// File: rtl/ddr4_dimm_cmd_tracker_if.sv
// DDR4 command/address bus seen by the command tracker.
// Modports:
//   master - the controller side that drives the command bus
//   slave  - the tracker side that samples it
// Signals: act_n, adr[16:0], ba[1:0], bg[BG_W-1:0], cs_n[RANKS-1:0], cke.
interface ddr4_dimm_cmd_tracker_if #(
  parameter int unsigned RANKS = 1,
  parameter int unsigned BG_W  = 1
);
  logic              c0_ddr4_act_n;
  logic [16:0]       c0_ddr4_adr;
  logic [1:0]        c0_ddr4_ba;
  logic [BG_W-1:0]   c0_ddr4_bg;
  logic [RANKS-1:0]  c0_ddr4_cs_n;
  logic              c0_ddr4_cke;

  modport master (
    output c0_ddr4_act_n, c0_ddr4_adr, c0_ddr4_ba, c0_ddr4_bg, c0_ddr4_cs_n, c0_ddr4_cke
  );

  modport slave (
    input  c0_ddr4_act_n, c0_ddr4_adr, c0_ddr4_ba, c0_ddr4_bg, c0_ddr4_cs_n, c0_ddr4_cke
  );
endinterface

// File: rtl/ddr4_dimm_cmd_tracker.sv
// DDR4 DIMM command tracker: decodes the command bus, tracks per-bank
// open/row state, counts ACT/RD/WR and flags protocol errors.
// Ports:
//   c0_ddr4_ck_t    - command clock (rising edge)
//   sys_reset       - synchronous active-high reset
//   bus             - command bus (ddr4_dimm_cmd_tracker_if.slave)
//   c0_ddr4_adr_int - combinational address, RAS/CAS/WE bits cleared for RD/WR
//   cmd_*           - registered decoded command, valid for one cycle with cmd_valid
//   open_mask       - one bit per bank, index rank*2^(BG_W+2) + {bg,ba}
//   act/rd/wr_cnt   - saturating command counters
//   err_pulse       - one-cycle pulse on any protocol error
//   err_status      - sticky error flags, cleared only by reset
// Build option: DDR4_TRACKER_FATAL_EN makes every protocol error call $fatal.
module ddr4_dimm_cmd_tracker #(
  parameter int unsigned RANKS = 1,
  parameter int unsigned BG_W  = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic                                c0_ddr4_ck_t,
  input  logic                                sys_reset,
  ddr4_dimm_cmd_tracker_if.slave              bus,
  output logic [16:0]                         c0_ddr4_adr_int,
  output logic                                cmd_valid,
  output logic [2:0]                          cmd_type,
  output logic [1:0]                          cmd_rank,
  output logic [BG_W+1:0]                     cmd_bank,
  output logic [16:0]                         cmd_row,
  output logic [9:0]                          cmd_col,
  output logic [RANKS*(1 << (BG_W+2))-1:0]    open_mask,
  output logic [CNT_W-1:0]                    act_cnt,
  output logic [CNT_W-1:0]                    rd_cnt,
  output logic [CNT_W-1:0]                    wr_cnt,
  output logic                                err_pulse,
  output logic [3:0]                          err_status
);

  localparam int unsigned BANK_W = BG_W + 2;
  localparam int unsigned NB     = 1 << BANK_W;
  localparam int unsigned NBANKS = RANKS * NB;
  localparam int unsigned IDX_W  = $clog2(NBANKS);

  localparam logic [2:0] CMD_ACT  = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_PRE  = 3'd3;
  localparam logic [2:0] CMD_PREA = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_MRS  = 3'd6;
  localparam logic [2:0] CMD_ZQ   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [16:0]        rows [NBANKS];
  logic [2:0]         cs_cnt;
  logic [1:0]         rank_c;
  logic [BANK_W-1:0]  bank_c;
  logic [IDX_W-1:0]   idx_c;
  logic [NBANKS-1:0]  rank_mask;
  logic               sel_c;
  logic               multi_c;
  logic               bank_open;
  logic               rank_open;
  logic [2:0]         op;

  logic               valid_c;
  logic [2:0]         type_c;
  logic [16:0]        row_c;
  logic [9:0]         col_c;
  logic [3:0]         err_c;
  logic [NBANKS-1:0]  open_nxt;
  logic               row_we;

  // RAS/CAS/WE ride on adr[16:14] for RD/WR; strip them for the column path
  always_comb begin
    c0_ddr4_adr_int = bus.c0_ddr4_adr;
    if (bus.c0_ddr4_act_n && (bus.c0_ddr4_adr[16:15] == 2'b10))
      c0_ddr4_adr_int[16:14] = 3'b000;
  end

  // Chip-select population count and selected rank
  always_comb begin
    cs_cnt = '0;
    rank_c = '0;
    for (int i = 0; i < RANKS; i++) begin
      if (!bus.c0_ddr4_cs_n[i]) begin
        cs_cnt = cs_cnt + 3'd1;
        rank_c = 2'(i);
      end
    end
  end

  // With cke low the bus is ignored entirely, including multi-CS checks
  assign sel_c     = bus.c0_ddr4_cke && (cs_cnt == 3'd1);
  assign multi_c   = bus.c0_ddr4_cke && (cs_cnt > 3'd1);
  assign bank_c    = {bus.c0_ddr4_bg, bus.c0_ddr4_ba};
  assign idx_c     = IDX_W'({rank_c, bank_c});
  assign rank_mask = {{(NBANKS-NB){1'b0}}, {NB{1'b1}}} << (32'(rank_c) * NB);
  assign bank_open = open_mask[idx_c];
  assign rank_open = |(open_mask & rank_mask);
  assign op        = bus.c0_ddr4_adr[16:14];

  // Command decode and next bank state
  always_comb begin
    valid_c  = 1'b0;
    type_c   = CMD_ACT;
    row_c    = '0;
    col_c    = '0;
    err_c    = '0;
    open_nxt = open_mask;
    row_we   = 1'b0;
    if (multi_c) begin
      err_c[3] = 1'b1;
    end else if (sel_c) begin
      if (!bus.c0_ddr4_act_n) begin
        valid_c         = 1'b1;
        type_c          = CMD_ACT;
        row_c           = bus.c0_ddr4_adr;
        row_we          = 1'b1;
        open_nxt[idx_c] = 1'b1;
        err_c[0]        = bank_open;
      end else begin
        case (op)
          3'b100, 3'b101: begin
            valid_c = 1'b1;
            type_c  = op[0] ? CMD_RD : CMD_WR;
            col_c   = bus.c0_ddr4_adr[9:0];
            if (bank_open) row_c    = rows[idx_c];
            else           err_c[1] = 1'b1;
            // Auto-precharge: reported row uses the pre-access state
            if (bus.c0_ddr4_adr[10]) open_nxt[idx_c] = 1'b0;
          end
          3'b010: begin
            valid_c = 1'b1;
            if (bus.c0_ddr4_adr[10]) begin
              type_c   = CMD_PREA;
              open_nxt = open_mask & ~rank_mask;
            end else begin
              type_c          = CMD_PRE;
              open_nxt[idx_c] = 1'b0;
            end
          end
          3'b001: begin
            valid_c  = 1'b1;
            type_c   = CMD_REF;
            err_c[2] = rank_open;
          end
          3'b000: begin
            valid_c = 1'b1;
            type_c  = CMD_MRS;
          end
          3'b110: begin
            valid_c = 1'b1;
            type_c  = CMD_ZQ;
          end
          3'b011:  err_c[3] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs, bank state and counters
  always_ff @(posedge c0_ddr4_ck_t) begin
    if (sys_reset) begin
      cmd_valid  <= 1'b0;
      cmd_type   <= '0;
      cmd_rank   <= '0;
      cmd_bank   <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      open_mask  <= '0;
      act_cnt    <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      err_pulse  <= 1'b0;
      err_status <= '0;
    end else begin
      cmd_valid  <= valid_c;
      err_pulse  <= |err_c;
      err_status <= err_status | err_c;
      open_mask  <= open_nxt;
      if (valid_c) begin
        cmd_type <= type_c;
        cmd_rank <= rank_c;
        cmd_bank <= bank_c;
        cmd_row  <= row_c;
        cmd_col  <= col_c;
      end
      if (valid_c && (type_c == CMD_ACT) && (act_cnt != CNT_MAX)) act_cnt <= act_cnt + CNT_W'(1);
      if (valid_c && (type_c == CMD_RD)  && (rd_cnt  != CNT_MAX)) rd_cnt  <= rd_cnt  + CNT_W'(1);
      if (valid_c && (type_c == CMD_WR)  && (wr_cnt  != CNT_MAX)) wr_cnt  <= wr_cnt  + CNT_W'(1);
    end
  end

  // Row storage needs no reset: a closed bank never exposes its row
  always_ff @(posedge c0_ddr4_ck_t) begin
    if (!sys_reset && row_we) rows[idx_c] <= bus.c0_ddr4_adr;
  end

`ifdef DDR4_TRACKER_FATAL_EN
  always @(posedge c0_ddr4_ck_t) begin
    if (!sys_reset && (|err_c))
      $fatal(1, "ddr4_dimm_cmd_tracker: protocol error at %0t rank %0d bank %0d err %b",
             $time, rank_c, bank_c, err_c);
  end
`endif

endmodule

// File: tb/tb_ddr4_dimm_cmd_tracker.sv
// Self-checking bench for ddr4_dimm_cmd_tracker (RANKS=2, BG_W=1, CNT_W=4):
// directed scenarios followed by random traffic against a bank-state model.
module tb_ddr4_dimm_cmd_tracker;
  localparam int unsigned RANKS = 2;
  localparam int unsigned BG_W  = 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NB    = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr4_dimm_cmd_tracker_if #(.RANKS(RANKS), .BG_W(BG_W)) bus ();

  logic [16:0]           adr_int;
  logic                  cmd_valid;
  logic [2:0]            cmd_type;
  logic [1:0]            cmd_rank;
  logic [BG_W+1:0]       cmd_bank;
  logic [16:0]           cmd_row;
  logic [9:0]            cmd_col;
  logic [RANKS*NB-1:0]   open_mask;
  logic [CNT_W-1:0]      act_cnt, rd_cnt, wr_cnt;
  logic                  err_pulse;
  logic [3:0]            err_status;

  ddr4_dimm_cmd_tracker #(.RANKS(RANKS), .BG_W(BG_W), .CNT_W(CNT_W)) dut (
    .c0_ddr4_ck_t    (clk),
    .sys_reset       (rst),
    .bus             (bus),
    .c0_ddr4_adr_int (adr_int),
    .cmd_valid       (cmd_valid),
    .cmd_type        (cmd_type),
    .cmd_rank        (cmd_rank),
    .cmd_bank        (cmd_bank),
    .cmd_row         (cmd_row),
    .cmd_col         (cmd_col),
    .open_mask       (open_mask),
    .act_cnt         (act_cnt),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .err_pulse       (err_pulse),
    .err_status      (err_status)
  );

  // Reference model: per-rank/per-bank open flag and row
  bit          m_open [RANKS][NB];
  logic [16:0] m_row  [RANKS][NB];
  int          m_act, m_rd, m_wr;
  logic [3:0]  m_stat;
  logic        e_valid, e_pulse;
  int          e_type, e_rank, e_bank, e_row, e_col;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic [2:0] op, input logic ap, input logic [9:0] col);
    return {op, 3'b000, ap, col};
  endfunction

  task automatic drv(input logic act_n, input logic [16:0] adr, input logic [1:0] ba,
                     input logic bg, input logic [1:0] cs_n, input logic cke);
    bus.c0_ddr4_act_n = act_n;
    bus.c0_ddr4_adr   = adr;
    bus.c0_ddr4_ba    = ba;
    bus.c0_ddr4_bg    = bg;
    bus.c0_ddr4_cs_n  = cs_n;
    bus.c0_ddr4_cke   = cke;
  endtask

  task automatic issue(input int t, input int r, input int b, input int row, input int col);
    e_valid = 1'b1;
    e_type  = t;
    e_rank  = r;
    e_bank  = b;
    e_row   = row;
    e_col   = col;
    if (t == 0 && m_act < CMAX) m_act++;
    if (t == 1 && m_rd  < CMAX) m_rd++;
    if (t == 2 && m_wr  < CMAX) m_wr++;
  endtask

  task automatic model_step();
    int nlow, r, b;
    logic [2:0]  op;
    logic [16:0] a;
    logic [3:0]  e;
    e = '0;
    e_valid = 1'b0;
    if (rst) begin
      for (int i = 0; i < RANKS; i++)
        for (int j = 0; j < NB; j++) m_open[i][j] = 1'b0;
      m_act = 0; m_rd = 0; m_wr = 0; m_stat = '0; e_pulse = 1'b0;
      return;
    end
    a = bus.c0_ddr4_adr;
    op = a[16:14];
    nlow = 0;
    r = 0;
    for (int i = 0; i < RANKS; i++)
      if (bus.c0_ddr4_cs_n[i] == 1'b0) begin nlow++; r = i; end
    b = int'(bus.c0_ddr4_bg) * 4 + int'(bus.c0_ddr4_ba);
    if (bus.c0_ddr4_cke && nlow >= 2) begin
      e[3] = 1'b1;
    end else if (bus.c0_ddr4_cke && nlow == 1) begin
      if (!bus.c0_ddr4_act_n) begin
        if (m_open[r][b]) e[0] = 1'b1;
        issue(0, r, b, int'(a), 0);
        m_open[r][b] = 1'b1;
        m_row[r][b]  = a;
      end else begin
        case (op)
          3'b101, 3'b100: begin
            issue((op == 3'b101) ? 1 : 2, r, b, m_open[r][b] ? int'(m_row[r][b]) : 0, int'(a[9:0]));
            if (!m_open[r][b]) e[1] = 1'b1;
            if (a[10]) m_open[r][b] = 1'b0;
          end
          3'b010: begin
            if (a[10]) begin
              issue(4, r, b, 0, 0);
              for (int j = 0; j < NB; j++) m_open[r][j] = 1'b0;
            end else begin
              issue(3, r, b, 0, 0);
              m_open[r][b] = 1'b0;
            end
          end
          3'b001: begin
            issue(5, r, b, 0, 0);
            for (int j = 0; j < NB; j++) if (m_open[r][j]) e[2] = 1'b1;
          end
          3'b000:  issue(6, r, b, 0, 0);
          3'b110:  issue(7, r, b, 0, 0);
          3'b011:  e[3] = 1'b1;
          default: ;
        endcase
      end
    end
    e_pulse = |e;
    m_stat  = m_stat | e;
  endtask

  task automatic check_all(input string tag);
    logic [RANKS*NB-1:0] m;
    for (int i = 0; i < RANKS; i++)
      for (int j = 0; j < NB; j++) m[i*NB+j] = m_open[i][j];
    chk({tag, ".cmd_valid"},  64'(cmd_valid),  64'(e_valid));
    chk({tag, ".err_pulse"},  64'(err_pulse),  64'(e_pulse));
    chk({tag, ".err_status"}, 64'(err_status), 64'(m_stat));
    chk({tag, ".open_mask"},  64'(open_mask),  64'(m));
    chk({tag, ".act_cnt"},    64'(act_cnt),    64'(m_act));
    chk({tag, ".rd_cnt"},     64'(rd_cnt),     64'(m_rd));
    chk({tag, ".wr_cnt"},     64'(wr_cnt),     64'(m_wr));
    if (e_valid) begin
      chk({tag, ".cmd_type"}, 64'(cmd_type), 64'(e_type));
      chk({tag, ".cmd_rank"}, 64'(cmd_rank), 64'(e_rank));
      chk({tag, ".cmd_bank"}, 64'(cmd_bank), 64'(e_bank));
      chk({tag, ".cmd_row"},  64'(cmd_row),  64'(e_row));
      chk({tag, ".cmd_col"},  64'(cmd_col),  64'(e_col));
    end
  endtask

  // Check the combinational address, clock one edge, then check registered outputs
  task automatic tick(input string tag);
    logic [16:0] ai;
    ai = bus.c0_ddr4_adr;
    if (bus.c0_ddr4_act_n && (ai[16:14] == 3'b100 || ai[16:14] == 3'b101)) ai[16:14] = 3'b000;
    #1;
    chk({tag, ".adr_int"}, 64'(adr_int), 64'(ai));
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".z_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, ".z_type"},  64'(cmd_type),  64'd0);
    chk({tag, ".z_rank"},  64'(cmd_rank),  64'd0);
    chk({tag, ".z_bank"},  64'(cmd_bank),  64'd0);
    chk({tag, ".z_row"},   64'(cmd_row),   64'd0);
    chk({tag, ".z_col"},   64'(cmd_col),   64'd0);
    chk({tag, ".z_open"},  64'(open_mask), 64'd0);
    chk({tag, ".z_cnt"},   64'({act_cnt, rd_cnt, wr_cnt}), 64'd0);
    chk({tag, ".z_err"},   64'({err_pulse, err_status}), 64'd0);
  endtask

  logic [RANKS*NB-1:0] saved_mask;

  initial begin
    int p;
    logic [1:0] cs;
    logic ck;

    // Reset state
    rst = 1'b1;
    drv(1'b1, mk(3'b111, 1'b0, 10'd0), 2'd0, 1'b0, 2'b11, 1'b1);
    @(posedge clk); #1;
    tick("reset");
    check_zero("reset");
    rst = 1'b0;

    // ACT r0 bg0 ba1 row 0x1234, then RD col 0x40
    drv(1'b0, 17'h01234, 2'd1, 1'b0, 2'b10, 1'b1);
    tick("act1");
    chk("act1.open1", 64'(open_mask[1]), 64'd1);
    drv(1'b1, mk(3'b101, 1'b0, 10'h040), 2'd1, 1'b0, 2'b10, 1'b1);
    tick("rd1");
    chk("rd1.type", 64'(cmd_type), 64'd1);
    chk("rd1.row",  64'(cmd_row),  64'h1234);
    chk("rd1.col",  64'(cmd_col),  64'h40);
    chk("rd1.rdcnt", 64'(rd_cnt),  64'd1);
    chk("rd1.open1", 64'(open_mask[1]), 64'd1);

    // WR with auto-precharge to open bank 1
    drv(1'b1, mk(3'b100, 1'b1, 10'h07f), 2'd1, 1'b0, 2'b10, 1'b1);
    tick("wrap");
    chk("wrap.wrcnt", 64'(wr_cnt), 64'd1);
    chk("wrap.open1", 64'(open_mask[1]), 64'd0);
    chk("wrap.err",   64'({err_pulse, err_status}), 64'd0);

    // RD to closed bank 3
    drv(1'b1, mk(3'b101, 1'b0, 10'h011), 2'd3, 1'b0, 2'b10, 1'b1);
    tick("rdcl");
    chk("rdcl.valid", 64'(cmd_valid), 64'd1);
    chk("rdcl.pulse", 64'(err_pulse), 64'd1);
    chk("rdcl.stat",  64'(err_status), 64'b0010);
    chk("rdcl.row",   64'(cmd_row), 64'd0);

    // Both chip selects low with ACT
    saved_mask = open_mask;
    drv(1'b0, 17'h00abc, 2'd2, 1'b0, 2'b00, 1'b1);
    tick("mcs");
    chk("mcs.valid", 64'(cmd_valid), 64'd0);
    chk("mcs.stat3", 64'(err_status[3]), 64'd1);
    chk("mcs.open",  64'(open_mask), 64'(saved_mask));

    // Banks 0 and 5 open, PREA then REF
    drv(1'b0, 17'h00100, 2'd0, 1'b0, 2'b10, 1'b1);
    tick("act0");
    drv(1'b0, 17'h00500, 2'd1, 1'b1, 2'b10, 1'b1);
    tick("act5");
    chk("act5.open", 64'(open_mask), 64'h0021);
    drv(1'b1, mk(3'b010, 1'b1, 10'd0), 2'd0, 1'b0, 2'b10, 1'b1);
    tick("prea");
    chk("prea.open", 64'(open_mask), 64'd0);
    drv(1'b1, mk(3'b001, 1'b0, 10'd0), 2'd0, 1'b0, 2'b10, 1'b1);
    tick("ref");
    chk("ref.stat2", 64'(err_status[2]), 64'd0);
    chk("ref.pulse", 64'(err_pulse), 64'd0);

    // 20 ACT/PRE pairs on rank 1 saturate the 4-bit ACT counter
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 17'(i), 2'd2, 1'b1, 2'b01, 1'b1);
      tick("pair.act");
      drv(1'b1, mk(3'b010, 1'b0, 10'd0), 2'd2, 1'b1, 2'b01, 1'b1);
      tick("pair.pre");
    end
    chk("sat.act", 64'(act_cnt), 64'd15);
    drv(1'b0, 17'h1ffff, 2'd2, 1'b1, 2'b01, 1'b1);
    tick("sat.more");
    chk("sat.held", 64'(act_cnt), 64'd15);

    // Reset mid-sequence with a command sampled in the reset cycle
    rst = 1'b1;
    drv(1'b0, 17'h00777, 2'd3, 1'b0, 2'b10, 1'b1);
    tick("rstmid");
    check_zero("rstmid");
    rst = 1'b0;
    drv(1'b1, mk(3'b111, 1'b0, 10'd0), 2'd0, 1'b0, 2'b11, 1'b1);
    tick("rstidle");
    chk("rstidle.open", 64'(open_mask), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      p  = int'($urandom_range(0, 99));
      ck = 1'b1;
      if (p < 70)      cs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      else if (p < 80) cs = 2'b11;
      else if (p < 88) cs = 2'b00;
      else begin
        cs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        ck = 1'b0;
      end
      rst = ($urandom_range(0, 99) < 2);
      drv(($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1, 17'($urandom), 2'($urandom), 1'($urandom), cs, ck);
      tick("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
